// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encoding, frame constants
// and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_FRAME_BITS  = 11;
  localparam int PS2_TIMEOUT_CYC = 10000;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on clock and data, a
// FILTER_LEN-sample glitch filter on the clock and a falling-edge strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic pclk,
  input  logic reset,
  input  logic ps2_clk_raw,
  input  logic ps2_data_raw,
  output logic clk_filt,
  output logic fall_strobe,
  output logic data_sync
);

  logic       clk_meta_q,  clk_meta_d;
  logic       clk_sync_q,  clk_sync_d;
  logic       data_meta_q, data_meta_d;
  logic       data_sync_q, data_sync_d;
  logic       filt_q,      filt_d;
  logic [3:0] cnt_q,       cnt_d;
  logic       strobe_q,    strobe_d;

  always_comb begin
    clk_meta_d  = ps2_clk_raw;
    clk_sync_d  = clk_meta_q;
    data_meta_d = ps2_data_raw;
    data_sync_d = data_meta_q;
    filt_d      = filt_q;
    cnt_d       = '0;
    // Count consecutive samples disagreeing with the filtered level; any
    // agreeing sample restarts the count.
    if (clk_sync_q != filt_q) begin
      if (cnt_q == 4'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    strobe_d = filt_q & ~filt_d;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      strobe_q    <= 1'b0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      strobe_q    <= strobe_d;
    end
  end

  assign clk_filt    = filt_q;
  assign fall_strobe = strobe_q;
  assign data_sync   = data_sync_q;

endmodule

// File: rtl/ps2_rx_sync.sv
// PS/2 keyboard frame receiver on pclk: deserialises 11-bit frames and hands
// scancodes out on a valid/ack level handshake. Define PS2_RX_INHIBIT_EN to hold the keyboard clock low while a byte is pending.
//
// state  | meaning
// IDLE   | waiting for a start bit (data=0 on strobe)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, delivering the byte
module ps2_rx_sync
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC,
  parameter int TO_W        = 14
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_err,
  output logic       overrun
);

  logic clk_filt, fall_strobe, data_sync, strb;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line_filter (
    .pclk        (pclk),
    .reset       (reset),
    .ps2_clk_raw (ps2_clk_in),
    .ps2_data_raw(ps2_data_in),
    .clk_filt    (clk_filt),
    .fall_strobe (fall_strobe),
    .data_sync   (data_sync)
  );

  ps2_state_e      state_q,    state_d;
  logic [2:0]      bitcnt_q,   bitcnt_d;
  logic [7:0]      sr_q,       sr_d;
  logic            parity_q,   parity_d;
  logic [TO_W-1:0] to_cnt_q,   to_cnt_d;
  logic [7:0]      rx_data_q,  rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_err_q,   rx_err_d;
  logic            overrun_q,  overrun_d;
  logic            clk_oe_q,   clk_oe_d;
  logic            mask_q,     mask_d;

  // Edges seen while inhibiting, or before the line has recovered high,
  // are artefacts of our own pull-down and must not be taken as bits.
  assign strb = fall_strobe & ~clk_oe_q & ~mask_q;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    sr_d       = sr_q;
    parity_d   = parity_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_err_d   = 1'b0;
    overrun_d  = 1'b0;
    to_cnt_d   = (state_q == IDLE) ? '0 : to_cnt_q + 1'b1;

    if (rx_ack && rx_valid_q) rx_valid_d = 1'b0;

    if (strb) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_sync) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          sr_d     = {data_sync, sr_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_sync;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_sync && odd_parity_ok(sr_q, parity_q)) begin
            if (!rx_valid_q || rx_ack) begin
              rx_data_d  = sr_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            rx_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
      rx_err_d = 1'b1;
      state_d  = IDLE;
      to_cnt_d = '0;
    end

`ifdef PS2_RX_INHIBIT_EN
    clk_oe_d = rx_valid_q && (state_q == IDLE);
`else
    clk_oe_d = 1'b0;
`endif
    mask_d = clk_oe_q | (mask_q & ~clk_filt);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      sr_q       <= '0;
      parity_q   <= 1'b0;
      to_cnt_q   <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      overrun_q  <= 1'b0;
      clk_oe_q   <= 1'b0;
      mask_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      sr_q       <= sr_d;
      parity_q   <= parity_d;
      to_cnt_q   <= to_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      overrun_q  <= overrun_d;
      clk_oe_q   <= clk_oe_d;
      mask_q     <= mask_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_err     = rx_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_rx_sync.sv
// Bench for ps2_rx_sync: frames are bit-banged on the PS/2 lines, expected
// deliveries/errors/overruns are queued and matched against DUT events.
module tb_ps2_rx_sync;

  localparam int HALF    = 20;
  localparam int TO_CYC  = 10000;
  localparam int STB_LAT = 7;
`ifdef PS2_RX_INHIBIT_EN
  localparam bit INH = 1'b1;
`else
  localparam bit INH = 1'b0;
`endif

  localparam int K_DATA = 0;
  localparam int K_ERR  = 1;
  localparam int K_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  logic       pclk, reset, ps2_clk_in, ps2_data_in, rx_ack;
  logic       ps2_clk_oe, rx_valid, rx_err, overrun;
  logic [7:0] rx_data;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb_q[$];

  logic       model_valid = 1'b0;
  logic [7:0] model_data  = 8'h00;
  int         first_low_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  ps2_rx_sync dut (
    .pclk       (pclk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_err     (rx_err),
    .overrun    (overrun)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sb_push(input int kind, input logic [7:0] data, input int exp_cyc);
    exp_t e;
    e.kind    = kind;
    e.data    = data;
    e.exp_cyc = exp_cyc;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [7:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_unexpected_event", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("sb_kind", kind, e.kind);
      check_eq("sb_data", {24'h0, data}, {24'h0, e.data});
      check_eq("sb_latency", cyc, e.exp_cyc);
    end
  endtask

  always @(negedge pclk) begin
    if (!reset) begin
      if (rx_err) sb_pop(K_ERR, 8'h00);
      if (overrun) sb_pop(K_OVR, 8'h00);
      if (rx_valid && (!prev_valid || rx_data != prev_data)) sb_pop(K_DATA, rx_data);
    end
    prev_valid <= rx_valid;
    prev_data  <= rx_data;
  end

  // Drives the first nbits of a frame; a full frame also queues its expectation.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_val,
                            input bit ack_at_stop, input bit glitch, input int nbits);
    logic [10:0] frame;
    logic        good;
    frame = {stop_val, ~(^b) ^ par_flip, b, 1'b0};
    good  = stop_val && !par_flip;
    for (int i = 0; i < nbits; i++) begin
      ps2_data_in = frame[i];
      if (glitch && i == 5) begin
        repeat (5) @(negedge pclk);
        ps2_clk_in = 1'b0;
        repeat (2) @(negedge pclk);
        ps2_clk_in = 1'b1;
        repeat (HALF - 7) @(negedge pclk);
      end else begin
        repeat (HALF) @(negedge pclk);
      end
      ps2_clk_in = 1'b0;
      if (i == 0) first_low_cyc = cyc;
      if (i == 10) begin
        if (INH && model_valid) begin
          if (ack_at_stop) model_valid = 1'b0;
        end else if (!good) begin
          sb_push(K_ERR, 8'h00, cyc + STB_LAT);
        end else if (model_valid && !ack_at_stop) begin
          sb_push(K_OVR, 8'h00, cyc + STB_LAT);
        end else begin
          sb_push(K_DATA, b, cyc + STB_LAT);
          model_valid = 1'b1;
          model_data  = b;
        end
      end
      for (int k = 0; k < HALF; k++) begin
        @(negedge pclk);
        rx_ack = ack_at_stop && (i == 10) && (k == 5);
      end
      ps2_clk_in = 1'b1;
    end
    ps2_data_in = 1'b1;
    repeat (HALF) @(negedge pclk);
  endtask

  task automatic do_ack();
    @(negedge pclk);
    rx_ack = 1'b1;
    @(negedge pclk);
    rx_ack = 1'b0;
    model_valid = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_valid"}, {31'h0, rx_valid}, {31'h0, model_valid});
    check_eq({tag, "_data"}, {24'h0, rx_data}, {24'h0, model_data});
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge pclk);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    ps2_clk_in  = 1'b1;
    ps2_data_in = 1'b1;
    rx_ack      = 1'b0;
    repeat (4) @(negedge pclk);
    check_eq("rst_valid", {31'h0, rx_valid}, 32'd0);
    check_eq("rst_data", {24'h0, rx_data}, 32'd0);
    check_eq("rst_err", {31'h0, rx_err}, 32'd0);
    check_eq("rst_ovr", {31'h0, overrun}, 32'd0);
    check_eq("rst_oe", {31'h0, ps2_clk_oe}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge pclk);

    // good frame, then consume it
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 11);
    check_model("good1c");
    check_eq("good1c_oe", {31'h0, ps2_clk_oe}, {31'h0, INH});
    do_ack();
    check_eq("ack_clears", {31'h0, rx_valid}, 32'd0);
    @(negedge pclk);
    check_eq("oe_release", {31'h0, ps2_clk_oe}, 32'd0);

    // parity error then stop-bit error
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 11);
    check_model("bad_frames");

    // second byte while first still pending
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 11);
    check_model("overrun");
    check_eq("overrun_oe", {31'h0, ps2_clk_oe}, {31'h0, INH});
    do_ack();
    check_model("overrun_ack");

    // ack coinciding with frame completion
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 11);
    check_model("ack_same_cycle");
    do_ack();

    // start bit followed by a stalled clock
    send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    sb_push(K_ERR, 8'h00, first_low_cyc + STB_LAT + TO_CYC);
    wait_drain(TO_CYC + 200);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 11);
    check_model("after_timeout");
    do_ack();

    // short clock glitch inside a frame
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 11);
    check_model("glitch");
    do_ack();

    // reset in the middle of a frame
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 11);
    check_model("pre_reset");
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 5);
    reset = 1'b1;
    repeat (2) @(negedge pclk);
    check_eq("midrst_valid", {31'h0, rx_valid}, 32'd0);
    check_eq("midrst_data", {24'h0, rx_data}, 32'd0);
    check_eq("midrst_oe", {31'h0, ps2_clk_oe}, 32'd0);
    reset       = 1'b0;
    model_valid = 1'b0;
    model_data  = 8'h00;
    repeat (4) @(negedge pclk);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 11);
    check_model("post_reset");
    do_ack();

    wait_drain(50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
